// File: rtl/crypto_accel_ctrl.sv
// crypto_accel_ctrl: MMIO front end for the AES engine.
// Single-outstanding AXI-Lite-style slave with block packer and splitter.
module crypto_accel_ctrl #(
    parameter int DATA_W     = 64,
    parameter int BLOCK_W    = 128,
    parameter int KEY_W      = 256,
    parameter int ADDR_W     = 38,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wraddr_valid,
    output logic               wraddr_ready,
    input  logic [ADDR_W-1:0]  wraddr,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [DATA_W-1:0]  wr_dat,
    output logic               wrresp_valid,
    input  logic               wrresp_ready,
    output logic [1:0]         wrresp_dat,
    input  logic               rdaddr_valid,
    output logic               rdaddr_ready,
    input  logic [ADDR_W-1:0]  rdaddr,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [DATA_W-1:0]  rd_dat,
    output logic [1:0]         rdresp_dat,
    output logic [KEY_W-1:0]   aes_key,
    output logic [BLOCK_W-1:0] aes_ctr,
    output logic               aes_in_valid,
    input  logic               aes_in_ready,
    output logic [BLOCK_W-1:0] aes_in_block,
    input  logic               aes_out_valid,
    output logic               aes_out_ready,
    input  logic [BLOCK_W-1:0] aes_out_block,
    input  logic               aes_fifo_empty,
    output logic               aes_rst,
    output logic               irq
);
    localparam int NB  = BLOCK_W / DATA_W;
    localparam int NK  = KEY_W / DATA_W;
    localparam int AL  = $clog2(DATA_W / 8);
    localparam int IW  = 16 - AL;
    localparam int PCW = $clog2(NB + 1);
    localparam int WCW = $clog2(RD_TIMEOUT + 2);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;
    state_t state, state_nx;

    logic [IW-1:0]      wa, ra, ri;
    logic [1:0]         wcode, rcode_q, rc_mux;
    logic [DATA_W-1:0]  rd_q, rd_mux;
    logic               soft_pulse, auto_inc, irq_en, irq_pending, to_sticky;
    logic [31:0]        blkcnt;
    logic [DATA_W-1:0]  pk_w [NB];
    logic [PCW-1:0]     pk_cnt, sp_left;
    logic [BLOCK_W-1:0] sp_blk, ctr_inc;
    logic [DATA_W-1:0]  ctr_w [NB];
    logic [DATA_W-1:0]  key_w [NK];
    logic [WCW-1:0]     wait_cnt;
    logic               aw_fire, ar_fire, wr_fire, rd_fire, in_fire, out_fire;
    logic               in_full, out_empty, busy, wa_fifo, ra_fifo;
    logic               to_hit, pop, push, w_ctl, w_sts;
    logic               unused;

    function automatic logic [1:0] wr_code_f(input logic [IW-1:0] w);
        int i;
        i = int'(w);
        if (i <= 2) return OKAY;
        if (i == 3) return SLVERR;
        if (i >= 8 && i < 8 + NB) return OKAY;
        if (i >= 16 && i < 16 + NK) return OKAY;
        return DECERR;
    endfunction

    assign unused = ^{wraddr[ADDR_W-1:16], wraddr[AL-1:0],
                      rdaddr[ADDR_W-1:16], rdaddr[AL-1:0]};

    assign ri        = rdaddr[15:AL];
    assign aw_fire   = wraddr_valid & wraddr_ready;
    assign ar_fire   = rdaddr_valid & rdaddr_ready;
    assign wr_fire   = wr_valid & wr_ready;
    assign rd_fire   = rd_valid & rd_ready;
    assign in_full   = pk_cnt == PCW'(NB);
    assign out_empty = sp_left == '0;
    assign busy      = !aes_fifo_empty || !out_empty || pk_cnt != '0;
    assign in_fire   = aes_in_valid & aes_in_ready;
    assign out_fire  = aes_out_valid & aes_out_ready;
    assign wa_fifo   = wa == IW'(1);
    assign ra_fifo   = ra == IW'(1);
    assign to_hit    = (RD_TIMEOUT != 0) && state == RD_DATA && ra_fifo
                       && wait_cnt == WCW'(RD_TIMEOUT);
    assign pop       = rd_fire && ra_fifo && !to_hit && !out_empty;
    assign push      = wr_fire && wa_fifo;
    assign w_ctl     = wr_fire && wa == IW'(0);
    assign w_sts     = wr_fire && wa == IW'(2);
    assign ctr_inc   = aes_ctr + 1'b1;

    assign aes_rst       = rst | soft_pulse;
    assign aes_in_valid  = in_full;
    assign aes_out_ready = out_empty;
    assign irq           = irq_pending & irq_en;

    always_comb begin
        aes_in_block = '0;
        aes_ctr      = '0;
        aes_key      = '0;
        for (int i = 0; i < NB; i++) begin
            aes_in_block[BLOCK_W-1-i*DATA_W -: DATA_W] = pk_w[i];
            aes_ctr[BLOCK_W-1-i*DATA_W -: DATA_W]      = ctr_w[i];
        end
        for (int i = 0; i < NK; i++)
            aes_key[KEY_W-1-i*DATA_W -: DATA_W] = key_w[i];
    end

    // Non-FIFO read data is snapshotted at the address handshake.
    always_comb begin
        rd_mux = '0;
        rc_mux = DECERR;
        if (int'(ri) == 0) begin
            rd_mux = DATA_W'({irq_en, auto_inc, 1'b0});
            rc_mux = OKAY;
        end else if (int'(ri) == 1) begin
            rc_mux = OKAY;
        end else if (int'(ri) == 2) begin
            rd_mux = DATA_W'({to_sticky, irq_pending, in_full, out_empty, busy});
            rc_mux = OKAY;
        end else if (int'(ri) == 3) begin
            rd_mux = DATA_W'(blkcnt);
            rc_mux = OKAY;
        end else if (int'(ri) >= 16 && int'(ri) < 16 + NK) begin
            rc_mux = SLVERR;
        end
        for (int i = 0; i < NB; i++) begin
            if (int'(ri) == 8 + i) begin
                rd_mux = ctr_w[i];
                rc_mux = OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (wraddr_valid)      state_nx = WR_DATA;
                else if (rdaddr_valid) state_nx = RD_DATA;
            end
            WR_DATA: if (wr_fire)      state_nx = WR_RESP;
            WR_RESP: if (wrresp_ready) state_nx = IDLE;
            RD_DATA: if (rd_fire)      state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    always_comb begin
        wraddr_ready = state == IDLE;
        rdaddr_ready = state == IDLE && !wraddr_valid;
        wr_ready     = state == WR_DATA && (!wa_fifo || !in_full);
        wrresp_valid = state == WR_RESP;
        wrresp_dat   = wrresp_valid ? wcode : 2'b00;
        rd_valid     = state == RD_DATA && (!ra_fifo || !out_empty || to_hit);
        rd_dat       = '0;
        rdresp_dat   = OKAY;
        if (rd_valid) begin
            if (!ra_fifo) begin
                rd_dat     = rd_q;
                rdresp_dat = rcode_q;
            end else if (to_hit) begin
                rdresp_dat = SLVERR;
            end else begin
                rd_dat     = sp_blk[BLOCK_W-1 -: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wa         <= '0;
            ra         <= '0;
            wcode      <= OKAY;
            rd_q       <= '0;
            rcode_q    <= OKAY;
            soft_pulse <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            soft_pulse <= w_ctl && wr_dat[0];
            if (aw_fire) wa <= wraddr[15:AL];
            if (wr_fire) wcode <= wr_code_f(wa);
            if (ar_fire) begin
                ra       <= ri;
                rd_q     <= rd_mux;
                rcode_q  <= rc_mux;
                wait_cnt <= '0;
            end else if (state == RD_DATA && ra_fifo && out_empty && !to_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aes_rst) begin
            auto_inc    <= 1'b0;
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
            to_sticky   <= 1'b0;
            blkcnt      <= '0;
            pk_cnt      <= '0;
            sp_left     <= '0;
            sp_blk      <= '0;
            for (int i = 0; i < NB; i++) begin
                pk_w[i]  <= '0;
                ctr_w[i] <= '0;
            end
            for (int i = 0; i < NK; i++) key_w[i] <= '0;
        end else begin
            if (w_ctl) begin
                auto_inc <= wr_dat[1];
                irq_en   <= wr_dat[2];
            end
            if (out_fire)              irq_pending <= 1'b1;
            else if (w_sts && wr_dat[3]) irq_pending <= 1'b0;
            if (rd_fire && ra_fifo && to_hit) to_sticky <= 1'b1;
            else if (w_sts && wr_dat[4])      to_sticky <= 1'b0;
            if (out_fire) begin
                sp_blk  <= aes_out_block;
                sp_left <= PCW'(NB);
                blkcnt  <= blkcnt + 32'd1;
            end else if (pop) begin
                sp_blk  <= sp_blk << DATA_W;
                sp_left <= sp_left - 1'b1;
            end
            if (in_fire)   pk_cnt <= '0;
            else if (push) pk_cnt <= pk_cnt + 1'b1;
            for (int i = 0; i < NB; i++) begin
                if (push && pk_cnt == PCW'(i)) pk_w[i] <= wr_dat;
                // A CPU write to one word beats the increment for that word only.
                if (wr_fire && int'(wa) == 8 + i)
                    ctr_w[i] <= wr_dat;
                else if (in_fire && auto_inc)
                    ctr_w[i] <= ctr_inc[BLOCK_W-1-i*DATA_W -: DATA_W];
            end
            for (int i = 0; i < NK; i++)
                if (wr_fire && int'(wa) == 16 + i) key_w[i] <= wr_dat;
        end
    end
endmodule

// File: tb/tb_crypto_accel_ctrl.sv
// Bench for crypto_accel_ctrl: directed and random bus/engine traffic
// compared against a queue-based register model.
module tb_crypto_accel_ctrl;
    localparam int DW  = 64;
    localparam int BW  = 128;
    localparam int KW  = 256;
    localparam int AW  = 38;
    localparam int TO  = 16;
    localparam int LIM = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wraddr_valid = 0, wraddr_ready;
    logic [AW-1:0] wraddr = '0;
    logic wr_valid = 0, wr_ready;
    logic [DW-1:0] wr_dat = '0;
    logic wrresp_valid, wrresp_ready = 0;
    logic [1:0] wrresp_dat;
    logic rdaddr_valid = 0, rdaddr_ready;
    logic [AW-1:0] rdaddr = '0;
    logic rd_valid, rd_ready = 0;
    logic [DW-1:0] rd_dat;
    logic [1:0] rdresp_dat;
    logic [KW-1:0] aes_key;
    logic [BW-1:0] aes_ctr;
    logic aes_in_valid, aes_in_ready = 0;
    logic [BW-1:0] aes_in_block;
    logic aes_out_valid = 0, aes_out_ready;
    logic [BW-1:0] aes_out_block = '0;
    logic aes_fifo_empty = 1;
    logic aes_rst, irq;

    always #5 clk = ~clk;

    crypto_accel_ctrl #(
        .DATA_W(DW), .BLOCK_W(BW), .KEY_W(KW), .ADDR_W(AW), .RD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .wraddr_valid(wraddr_valid), .wraddr_ready(wraddr_ready), .wraddr(wraddr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat),
        .wrresp_valid(wrresp_valid), .wrresp_ready(wrresp_ready),
        .wrresp_dat(wrresp_dat),
        .rdaddr_valid(rdaddr_valid), .rdaddr_ready(rdaddr_ready), .rdaddr(rdaddr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_dat(rd_dat),
        .rdresp_dat(rdresp_dat),
        .aes_key(aes_key), .aes_ctr(aes_ctr),
        .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready),
        .aes_in_block(aes_in_block),
        .aes_out_valid(aes_out_valid), .aes_out_ready(aes_out_ready),
        .aes_out_block(aes_out_block),
        .aes_fifo_empty(aes_fifo_empty), .aes_rst(aes_rst), .irq(irq)
    );

    int total = 0, passed = 0, fails = 0;
    int arst_cnt = 0;
    always @(negedge clk) if (aes_rst) arst_cnt++;

    logic [BW-1:0] m_ctr = '0;
    logic [KW-1:0] m_key = '0;
    logic m_inc = 0, m_ien = 0, m_irq = 0, m_to = 0;
    int unsigned m_blk = 0;
    logic [DW-1:0] m_inq[$];
    logic [DW-1:0] m_outq[$];

    function automatic logic [AW-1:0] A(input int w);
        return AW'(w * (DW / 8));
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        total++;
        fails++;
        $error("FAIL %s: timeout observed no handshake expected one", tag);
    endtask

    task automatic m_soft();
        m_ctr = '0; m_key = '0; m_inc = 0; m_ien = 0;
        m_irq = 0; m_to = 0; m_blk = 0;
        m_inq.delete(); m_outq.delete();
    endtask

    task automatic m_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [1:0] code);
        int w;
        w = int'(a[15:3]);
        code = 2'b00;
        if (w == 0) begin
            m_inc = d[1]; m_ien = d[2];
            if (d[0]) m_soft();
        end else if (w == 1) m_inq.push_back(d);
        else if (w == 2) begin
            if (d[3]) m_irq = 0;
            if (d[4]) m_to = 0;
        end else if (w == 3) code = 2'b10;
        else if (w >= 8 && w < 8 + BW / DW) m_ctr[BW-1-(w-8)*DW -: DW] = d;
        else if (w >= 16 && w < 16 + KW / DW) m_key[KW-1-(w-16)*DW -: DW] = d;
        else code = 2'b11;
    endtask

    task automatic m_rd(input logic [AW-1:0] a, output logic [DW-1:0] d,
                        output logic [1:0] code);
        int w;
        logic busy;
        w = int'(a[15:3]);
        d = '0;
        code = 2'b00;
        busy = !aes_fifo_empty || m_inq.size() != 0 || m_outq.size() != 0;
        if (w == 0) d = DW'({m_ien, m_inc, 1'b0});
        else if (w == 1) begin
            if (m_outq.size() > 0) d = m_outq.pop_front();
            else begin code = 2'b10; m_to = 1; end
        end else if (w == 2)
            d = DW'({m_to, m_irq, m_inq.size() == BW / DW, m_outq.size() == 0, busy});
        else if (w == 3) d = DW'(m_blk);
        else if (w >= 8 && w < 8 + BW / DW) d = m_ctr[BW-1-(w-8)*DW -: DW];
        else if (w >= 16 && w < 16 + KW / DW) code = 2'b10;
        else code = 2'b11;
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [1:0] code);
        int n;
        @(negedge clk);
        wraddr = a; wraddr_valid = 1;
        n = 0;
        while (!wraddr_ready && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("wraddr");
        @(negedge clk);
        wraddr_valid = 0; wr_dat = d; wr_valid = 1;
        n = 0;
        while (!wr_ready && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("wr_ready");
        @(negedge clk);
        wr_valid = 0; wrresp_ready = 1;
        n = 0;
        while (!wrresp_valid && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("wrresp");
        code = wrresp_dat;
        @(negedge clk);
        wrresp_ready = 0;
    endtask

    task automatic bus_rd(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [1:0] code, output int waited);
        int n;
        @(negedge clk);
        rdaddr = a; rdaddr_valid = 1;
        n = 0;
        while (!rdaddr_ready && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("rdaddr");
        @(negedge clk);
        rdaddr_valid = 0; rd_ready = 1;
        n = 0;
        while (!rd_valid && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("rd_valid");
        waited = n; d = rd_dat; code = rdresp_dat;
        @(negedge clk);
        rd_ready = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [1:0] c, ec;
        bus_wr(a, d, c);
        m_wr(a, d, ec);
        chk($sformatf("wr %0h code", a), c, ec);
    endtask

    task automatic rd(input logic [AW-1:0] a, output int waited);
        logic [DW-1:0] d, ed;
        logic [1:0] c, ec;
        bus_rd(a, d, c, waited);
        m_rd(a, ed, ec);
        chk($sformatf("rd %0h data", a), d, ed);
        chk($sformatf("rd %0h code", a), c, ec);
    endtask

    task automatic eng_take(input string tag);
        @(negedge clk);
        chk({tag, " in_valid"}, aes_in_valid, 1'b1);
        chk({tag, " in_block"}, aes_in_block, {m_inq[0], m_inq[1]});
        aes_in_ready = 1;
        @(negedge clk);
        aes_in_ready = 0;
        m_inq.delete();
        if (m_inc) m_ctr = m_ctr + 1'b1;
    endtask

    task automatic eng_give(input logic [BW-1:0] b);
        int n;
        @(negedge clk);
        aes_out_valid = 1; aes_out_block = b;
        n = 0;
        while (!aes_out_ready && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("aes_out_ready");
        @(negedge clk);
        aes_out_valid = 0;
        m_outq.push_back(b[BW-1:DW]);
        m_outq.push_back(b[DW-1:0]);
        m_irq = 1;
        m_blk++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt, n;
        logic [DW-1:0] p0, p1, p2, p3;
        logic [1:0] c;

        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst wraddr_ready", wraddr_ready, 1'b1);
        chk("rst wr_ready", wr_ready, 1'b0);
        chk("rst wrresp", {wrresp_valid, wrresp_dat}, 3'b000);
        chk("rst rd", {rd_valid, rdresp_dat}, 3'b000);
        chk("rst in_valid", aes_in_valid, 1'b0);
        chk("rst out_ready", aes_out_ready, 1'b1);
        chk("rst irq", irq, 1'b0);
        chk("rst aes_rst", aes_rst, 1'b0);
        chk("rst key", aes_key, '0);
        chk("rst ctr", aes_ctr, '0);

        for (int i = 0; i < 4; i++) wr(A(16 + i), DW'(i + 1));
        wr(A(8), '0);
        wr(A(9), '1);
        wr(A(0), 64'h2);
        chk("t1 key", aes_key, m_key);
        chk("t1 ctr", aes_ctr, m_ctr);
        wr(A(1), {$urandom, $urandom});
        wr(A(1), {$urandom, $urandom});
        eng_take("t1");
        rd(A(8), wt);
        rd(A(9), wt);
        chk("t1 ctr after", aes_ctr, {64'd1, 64'd0});

        eng_give({64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB});
        chk("t2 irq masked", irq, 1'b0);
        aes_fifo_empty = 0;
        rd(A(2), wt);
        aes_fifo_empty = 1;
        rd(A(1), wt);
        rd(A(1), wt);
        rd(A(3), wt);
        wr(A(0), 64'h6);
        chk("t2 irq on", irq, m_irq & m_ien);
        wr(A(2), 64'h8);
        chk("t2 irq cleared", irq, 1'b0);

        rd(A(1), wt);
        chk("t3 wait count", wt, TO);
        rd(A(2), wt);
        wr(A(2), 64'h10);
        rd(A(2), wt);

        rd(A(16), wt);
        rd(A(40), wt);
        wr(A(40), 64'h5);
        wr(A(3), 64'h77);
        rd(A(3), wt);
        wr(A(8) | (AW'(1) << 37), 64'h1234_5678);
        rd(A(8), wt);

        p0 = {$urandom, $urandom}; p1 = {$urandom, $urandom};
        p2 = {$urandom, $urandom}; p3 = {$urandom, $urandom};
        wr(A(1), p0);
        wr(A(1), p1);
        chk("t5 in_full", aes_in_valid, 1'b1);
        @(negedge clk);
        wraddr = A(1); wraddr_valid = 1;
        @(negedge clk);
        wraddr_valid = 0; wr_dat = p2; wr_valid = 1;
        chk("t5 stall a", wr_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5 stall b", wr_ready, 1'b0);
        eng_take("t5");
        chk("t5 wr_ready", wr_ready, 1'b1);
        @(negedge clk);
        wr_valid = 0; wrresp_ready = 1;
        m_inq.push_back(p2);
        chk("t5 resp", {wrresp_valid, wrresp_dat}, 3'b100);
        @(negedge clk);
        wrresp_ready = 0;
        wr(A(1), p3);
        eng_take("t5b");

        for (int it = 0; it < 5; it++) begin
            if (it == 2) begin
                wr(A(8), '1);
                wr(A(9), '1);
            end else begin
                wr(A(8 + int'($urandom_range(0, 1))), {$urandom, $urandom});
            end
            wr(A(16 + int'($urandom_range(0, 3))), {$urandom, $urandom});
            chk("rnd key", aes_key, m_key);
            wr(A(1), {$urandom, $urandom});
            wr(A(1), {$urandom, $urandom});
            eng_take("rnd");
            chk("rnd ctr", aes_ctr, m_ctr);
            eng_give({$urandom, $urandom, $urandom, $urandom});
            rd(A(1), wt);
            rd(A(1), wt);
            rd(A(3), wt);
        end

        wr(A(17), {$urandom, $urandom});
        wr(A(9), {$urandom, $urandom});
        wr(A(1), {$urandom, $urandom});
        eng_give({$urandom, $urandom, $urandom, $urandom});
        @(posedge clk);
        arst_cnt = 0;
        wr(A(0), 64'h1);
        repeat (2) @(negedge clk);
        chk("t6 aes_rst pulses", arst_cnt, 1);
        chk("t6 key", aes_key, '0);
        chk("t6 ctr", aes_ctr, '0);
        chk("t6 out_ready", aes_out_ready, 1'b1);
        rd(A(3), wt);
        rd(A(9), wt);
        rd(A(0), wt);
        rd(A(2), wt);
        wr(A(1), p0);
        wr(A(1), p3);
        eng_take("t6");

        p1 = {$urandom, $urandom};
        @(negedge clk);
        wraddr = A(9); wraddr_valid = 1;
        rdaddr = A(9); rdaddr_valid = 1;
        n = 0;
        while (!wraddr_ready && n < LIM) begin @(negedge clk); n++; end
        @(negedge clk);
        wraddr_valid = 0; wr_dat = p1; wr_valid = 1;
        n = 0;
        while (!wr_ready && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("sim wr_ready");
        @(negedge clk);
        wr_valid = 0; wrresp_ready = 1;
        n = 0;
        while (!wrresp_valid && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("sim wrresp");
        m_wr(A(9), p1, c);
        chk("sim wr code", wrresp_dat, c);
        chk("sim rd not yet", rd_valid, 1'b0);
        @(negedge clk);
        wrresp_ready = 0;
        n = 0;
        while (!rdaddr_ready && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("sim rdaddr");
        @(negedge clk);
        rdaddr_valid = 0; rd_ready = 1;
        n = 0;
        while (!rd_valid && n < LIM) begin @(negedge clk); n++; end
        if (n >= LIM) tmo("sim rd_valid");
        chk("sim rd data", rd_dat, m_ctr[DW-1:0]);
        chk("sim rd code", rdresp_dat, 2'b00);
        @(negedge clk);
        rd_ready = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
